// File: rtl/rtype_pipe_core.sv
// Three-stage (ID/EX/WB) execution core for the 32-bit R/I instruction format.
// It contains the register bank, ALU, data memory and the forward-or-stall hazard logic.
module rtype_pipe_core #(
  parameter int DATA_W = 32,
  parameter int DM_AW  = 7,
  parameter int FWD_EN = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              wb_valid,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  output logic              err_illegal
);

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic       FWD     = (FWD_EN != 0);

  function automatic logic is_rtype(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT};
  endfunction

  function automatic logic is_writer(input logic [5:0] op);
    return is_rtype(op) || op == OP_ADDI || op == OP_LW;
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return is_writer(op) || op == OP_SW;
  endfunction

  logic [5:0]        id_op;
  logic [10:0]       id_imm;
  logic [4:0]        id_wa, id_ra1, id_ra2;
  logic              id_use1, id_use2;
  logic [DATA_W-1:0] id_a, id_b;

  logic [DATA_W-1:0] regs [32];
  logic [DATA_W-1:0] dm [0:(1<<DM_AW)-1];

  logic              ex_valid;
  logic [5:0]        ex_op;
  logic [4:0]        ex_wa;
  logic [DATA_W-1:0] ex_a, ex_b, ex_imm, ex_alu;
  logic              ex_writer, ex_load, ex_store, ex_illegal;
  logic [DM_AW-1:0]  dm_idx;

  logic ex_hit1, ex_hit2, wb_hit1, wb_hit2, stall, accept;

  assign id_op   = instr[31:26];
  assign id_imm  = instr[25:15];
  assign id_wa   = instr[14:10];
  assign id_ra1  = instr[9:5];
  assign id_ra2  = instr[4:0];
  assign id_use1 = is_legal(id_op);
  assign id_use2 = is_rtype(id_op) || id_op == OP_SW;

  assign ex_writer  = ex_valid && is_writer(ex_op);
  assign ex_load    = ex_valid && ex_op == OP_LW;
  assign ex_store   = ex_valid && ex_op == OP_SW;
  assign ex_illegal = ex_valid && !is_legal(ex_op);
  assign dm_idx     = ex_alu[DM_AW-1:0];

  assign ex_hit1 = id_use1 && id_ra1 != 5'd0 && ex_writer && ex_wa == id_ra1;
  assign ex_hit2 = id_use2 && id_ra2 != 5'd0 && ex_writer && ex_wa == id_ra2;
  assign wb_hit1 = id_use1 && id_ra1 != 5'd0 && wb_valid && wb_addr == id_ra1;
  assign wb_hit2 = id_use2 && id_ra2 != 5'd0 && wb_valid && wb_addr == id_ra2;

  // With bypass only a load still in EX blocks issue; without it any pending writer does.
  assign stall = FWD ? ((ex_hit1 || ex_hit2) && ex_load)
                     : (ex_hit1 || ex_hit2 || wb_hit1 || wb_hit2);
  assign instr_ready = !RST && !stall;
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    id_a = regs[id_ra1];
    if (id_ra1 == 5'd0)       id_a = '0;
    else if (FWD && ex_hit1)  id_a = ex_alu;
    else if (FWD && wb_hit1)  id_a = wb_data;
  end

  always_comb begin
    id_b = regs[id_ra2];
    if (id_ra2 == 5'd0)       id_b = '0;
    else if (FWD && ex_hit2)  id_b = ex_alu;
    else if (FWD && wb_hit2)  id_b = wb_data;
  end

  always_comb begin
    ex_alu = '0;
    case (ex_op)
      OP_ADD:                  ex_alu = ex_a + ex_b;
      OP_SUB:                  ex_alu = ex_a - ex_b;
      OP_AND:                  ex_alu = ex_a & ex_b;
      OP_OR:                   ex_alu = ex_a | ex_b;
      OP_NOR:                  ex_alu = ~(ex_a | ex_b);
      OP_SLT:                  ex_alu = {{(DATA_W-1){1'b0}}, ex_a < ex_b};
      OP_ADDI, OP_LW, OP_SW:   ex_alu = ex_a + ex_imm;
      default:                 ex_alu = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_wa    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_imm   <= '0;
    end else begin
      ex_valid <= accept;
      if (accept) begin
        ex_op  <= id_op;
        ex_wa  <= id_wa;
        ex_a   <= id_a;
        ex_b   <= id_b;
        ex_imm <= {{(DATA_W-11){id_imm[10]}}, id_imm};
      end
    end
  end

  // Data memory has no reset; a store caught by reset is dropped.
  always_ff @(posedge CLK) begin
    if (!RST && ex_store) dm[dm_idx] <= ex_b;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      zero_flag   <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      wb_valid    <= ex_writer;
      wb_addr     <= ex_valid ? ex_wa : 5'd0;
      wb_data     <= !ex_valid ? '0 : (ex_load ? dm[dm_idx] : ex_alu);
      zero_flag   <= ex_valid && is_legal(ex_op) && ex_alu == '0;
      err_illegal <= ex_illegal;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_valid && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

endmodule

// File: doc/rtype_pipe_core.md
# rtype_pipe_core

Parametrised three-stage pipelined execution core for the team's 32-bit instruction format (op[31:26], imm[25:15], WA[14:10], RA1[9:5], RA2[4:0]). It integrates the following into one clocked block:
- a reset-cleared register bank;
- ALU;
- word-addressed data memory;
- hazard logic that either forwards results or stalls the input.

It sits between the instruction fetch/issue logic, which drives `instr`/`instr_valid`, and any observer of the write-back bus `wb_*`.

## Interface
- `DATA_W`, 32: datapath and register width. Must be ≥ 16.
- `DM_AW`, 7: data-memory address width. Depth is 2^DM_AW words.
- `FWD_EN`, 1: 1 = bypass network with a 1-cycle load-use stall; 0 = no bypass, stall until the producer is written.
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `instr`  in  32  instruction word.
- `instr_valid`  in  1  `instr` is presented.
- `instr_ready`  out  1  the core accepts `instr` on this edge. Accept = `instr_valid & instr_ready`.
- `wb_valid`  out  1  a write-back occurs at the next edge.
- `wb_addr`  out  5  destination register.
- `wb_data`  out  DATA_W  write-back value.
- `zero_flag`  out  1  ALU result == 0 for the instruction in WB.
- `err_illegal`  out  1  one-cycle pulse for an accepted unknown opcode.

## Operation
- Opcodes and their results:
  - ADD 100000: R[WA] = R[RA1]+R[RA2]
  - SUB 100010: R[WA] = R[RA1]−R[RA2]
  - AND 100100: R[WA] = R[RA1]&R[RA2]
  - OR 100101: R[WA] = R[RA1]|R[RA2]
  - NOR 100111: R[WA] = ~(R[RA1]|R[RA2])
  - SLT 101010: R[WA] = (R[RA1] < R[RA2]) ? 1 : 0, unsigned compare
  - ADDI 001000: R[WA] = R[RA1]+sext(imm)
  - LW 100011: R[WA] = DM[(R[RA1]+sext(imm))[DM_AW-1:0]]
  - SW 101011: DM[same address] = R[RA2]; no register write
- Arithmetic is modulo 2^DATA_W. imm is sign-extended from 11 bits. Address bits above DM_AW are ignored, so addresses wrap.
- Register 0 always reads 0. Writes to register 0 are dropped, and it never causes a hazard.
- Any other opcode is accepted and becomes a bubble: no register or memory effect, and `err_illegal` = 1 in the WB cycle.
- Stages:
  - ID: operand capture at the accept edge.
  - EX: ALU, SW memory write, and LW synchronous memory read at the next edge.
  - WB: register bank write at the following edge.
- Sources: R-type and SW read RA1 and RA2. ADDI and LW read RA1 only. A hazard exists only if a source is nonzero and equals the WA of a valid writer in EX or WB.
- FWD_EN=1:
  - Operand priority: EX ALU result > WB data > register bank.
  - If the EX instruction is an LW matching a source, `instr_ready` = 0 for 1 cycle. The LW data is then forwarded from WB.
- FWD_EN=0: `instr_ready` = 0 while any EX or WB writer matches a source. The register bank is read after the write edge.
- No downstream backpressure exists. `instr_ready` depends only on `RST` and hazards. When `instr_valid` = 0, bubbles advance.
- Register bank reset: all 32 registers are cleared to 0 on `RST`. Data memory is not reset.

## Timing
- Under `RST`:
  - `instr_ready` = 0
  - `wb_valid`, `wb_addr`, `wb_data`, `zero_flag`, `err_illegal` = 0 at the edge
  - pipeline valid bits cleared
  - an in-flight SW/LW/write is abandoned; a SW not yet at its EX edge never writes.
- Latency, accept at edge N:
  - SW memory write and LW read at edge N+1;
  - `wb_*`/`zero_flag`/`err_illegal` valid during cycle N+1..N+2;
  - register write at edge N+2.
- Throughput is 1 instruction per cycle with no hazard.
- Dependent-issue stall cycles (producer accepted the cycle before):
  - FWD_EN=1: 0 for ALU producers, 1 for LW.
  - FWD_EN=0: 2.
- A WB write and a same-edge ID read of the same register: the ID read takes the new value, via bypass (FWD_EN=1) or the stall (FWD_EN=0).
- Simultaneous SW then LW to the same address on consecutive accepts: the LW returns the stored data.

## Test plan
- Reset:
  - Stimulus: `RST`=1 for 2 cycles with `instr_valid`=1 and an ADDI.
  - Required: `instr_ready`=0 and `wb_valid`=0 throughout.
  - Then: ADD r3=r1+r2 → `wb_data`=0, `zero_flag`=1.
- Forwarding, FWD_EN=1:
  - Stimulus: back-to-back ADDI r1,r0,5; ADDI r2,r0,−3; ADD r3,r1,r2; SLT r4,r2,r1.
  - Required: no stall; r3=2, r4=0 (0xFFFFFFFD unsigned is not < 5).
- Load-use:
  - Stimulus: SW r1→DM[r0+4], then LW r5←DM[4], then ADD r6,r5,r5.
  - Required: exactly 1 `instr_ready`-low cycle with FWD_EN=1, r6=10.
  - Same sequence with FWD_EN=0: 2 stall cycles, same result.
- Wrap and r0:
  - Stimulus: DM_AW=7, SW to address 130.
  - Required: address 2 is written.
  - Stimulus: ADDI r0,r0,7.
  - Required: `wb_valid`=1, `wb_addr`=0, but a later read of r0 gives 0 and causes no stall.
- Illegal opcode:
  - Stimulus: opcode 111111 between two ADDIs.
  - Required: `err_illegal` pulses for 1 cycle; no register or memory change; the neighbouring results are correct.
- Mid-operation reset:
  - Stimulus: assert `RST` while a SW is in ID.
  - Required: DM is unchanged; all outputs are 0 on the next cycle.
